// File: rtl/ram_sum_sequencer_if.sv
// RAM-side bus used by ram_sum_sequencer.
//   address : word address into the 1024 x 10 RAM
//   we      : synchronous write enable
//   wdata   : write data
//   rdata   : asynchronous read data for the current address
// master modport is the sequencer; slave modport is the RAM.
interface ram_sum_sequencer_if;
  logic [9:0] address;
  logic       we;
  logic [9:0] wdata;
  logic [9:0] rdata;

  modport master (output address, output we, output wdata, input rdata);
  modport slave  (input address, input we, input wdata, output rdata);
endinterface

// File: rtl/ram_sum_sequencer.sv
// ram_sum_sequencer: on a start pulse, fetches a base pointer from RAM[PTR_ADDR],
// sums NUM_OPS consecutive signed 10-bit words starting at that pointer, writes
// the sum to the word after the operands and reports result/overflow.
// Ports:
//   clk      : rising-edge clock
//   reset    : asynchronous active-high reset
//   start    : one-cycle request, sampled only in IDLE
//   ram      : RAM bus (address/we/wdata out, rdata in)
//   busy     : high in every state except IDLE
//   done     : one-cycle completion pulse
//   result   : last sum written, held until the next completion
//   overflow : sticky signed overflow of the last run, held with result
module ram_sum_sequencer #(
  parameter logic [9:0]  PTR_ADDR = 10'd0,
  parameter int unsigned NUM_OPS  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  ram_sum_sequencer_if.master     ram,
  output logic                    busy,
  output logic                    done,
  output logic [9:0]              result,
  output logic                    overflow
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_READ,
    S_WRITE,
    S_DONE
  } state_e;

  state_e     state_q, state_d;
  logic [9:0] ptr_q, ptr_d;
  logic [9:0] acc_q, acc_d;
  logic       ovf_q, ovf_d;
  logic [4:0] idx_q, idx_d;
  logic [9:0] result_q, result_d;
  logic       overflow_q, overflow_d;
  logic [9:0] address_q, address_d;
  logic       we_q, we_d;
  logic [9:0] wdata_q, wdata_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [9:0] sum;

  // Every output is a flop, so each one is decoded from the next state and
  // the next datapath values rather than from the current state.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    acc_d      = acc_q;
    ovf_d      = ovf_q;
    idx_d      = idx_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    sum        = acc_q + ram.rdata;

    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        ptr_d   = ram.rdata;
        acc_d   = '0;
        ovf_d   = 1'b0;
        idx_d   = '0;
        state_d = S_READ;
      end
      S_READ: begin
        acc_d = sum;
        // Signed overflow: operands agree in sign, sum disagrees.
        ovf_d = ovf_q | ((acc_q[9] == ram.rdata[9]) && (sum[9] != acc_q[9]));
        idx_d = idx_q + 5'd1;
        if (idx_q == 5'(NUM_OPS - 1)) state_d = S_WRITE;
      end
      S_WRITE: begin
        result_d   = acc_q;
        overflow_d = ovf_q;
        state_d    = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    address_d = PTR_ADDR;
    we_d      = 1'b0;
    wdata_d   = '0;
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
    unique case (state_d)
      S_READ:  address_d = ptr_d + 10'(idx_d);
      S_WRITE: begin
        address_d = ptr_d + 10'(NUM_OPS);
        we_d      = 1'b1;
        wdata_d   = acc_d;
      end
      default: address_d = PTR_ADDR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      idx_q      <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      address_q  <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
      idx_q      <= idx_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
      address_q  <= address_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign ram.address = address_q;
  assign ram.we      = we_q;
  assign ram.wdata   = wdata_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign overflow    = overflow_q;

endmodule
